// File: rtl/key_pkg.sv
// Shared widths, types and FSM encoding for the round-key feeder and its key schedule.
package key_pkg;

  localparam int unsigned ROUND_KEY_W    = 8;
  localparam int unsigned NUM_ROUND_KEYS = 4;
  localparam int unsigned KEY_W          = 32;
  localparam int unsigned IDX_W          = $clog2(NUM_ROUND_KEYS);

  typedef logic [ROUND_KEY_W-1:0] round_key_t;
  typedef round_key_t [NUM_ROUND_KEYS-1:0] rk_array_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } feeder_state_t;

  // Odd parity of the master key selects the direct byte split.
  function automatic logic key_parity(input logic [KEY_W-1:0] k);
    return ^k;
  endfunction

endpackage

// File: rtl/key_schedule.sv
// Combinational key schedule: master key K -> round keys K0..K3.
// Ports:
//   key          in  master key
//   round_keys_c out K0..K3 (element i is Ki)
module key_schedule
  import key_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  output rk_array_t        round_keys_c
);

  logic [KEY_W-1:0] sched_word;

  // Even parity: keep the top nibble, rotate the low 28 bits right by 4.
  always_comb begin
    sched_word = key;
    if (!key_parity(key)) begin
      sched_word = {key[31:28], key[3:0], key[27:4]};
    end
  end

  always_comb begin
    round_keys_c = '0;
    for (int i = 0; i < int'(NUM_ROUND_KEYS); i++) begin
      round_keys_c[i] = sched_word[i*ROUND_KEY_W +: ROUND_KEY_W];
    end
  end

endmodule

// File: rtl/decrypt_key_feeder.sv
// Accepts one master key, expands it to four round keys and streams them
// one per handshake beat (K3..K0 when REVERSE, else K0..K3).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   key_valid/key_ready/key    master key handshake
//   rk_valid/rk_ready/rk       round key stream
//   rk_idx, rk_last            index of presented key, final beat marker
//   flush                      abandon the current stream
//   busy                       a key is held (SEND)
module decrypt_key_feeder
  import key_pkg::*;
#(
  parameter bit REVERSE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_valid,
  output logic                   key_ready,
  input  logic [KEY_W-1:0]       key,
  output logic                   rk_valid,
  input  logic                   rk_ready,
  output logic [ROUND_KEY_W-1:0] rk,
  output logic [IDX_W-1:0]       rk_idx,
  output logic                   rk_last,
  input  logic                   flush,
  output logic                   busy
);

  localparam logic [IDX_W-1:0] FIRST_IDX = REVERSE ? IDX_W'(NUM_ROUND_KEYS - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = REVERSE ? '0 : IDX_W'(NUM_ROUND_KEYS - 1);

  feeder_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  rk_array_t        rk_buf_q, rk_buf_d;
  rk_array_t        round_keys_c;

  key_schedule u_key_schedule (
    .key          (key),
    .round_keys_c (round_keys_c)
  );

  // State, index and buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rk_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rk_buf_q <= rk_buf_d;
    end
  end

  // Next-state and output decode; all outputs are functions of the registers only.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rk_buf_d  = rk_buf_q;
    key_ready = 1'b0;
    rk_valid  = 1'b0;
    busy      = 1'b0;
    rk        = '0;
    rk_idx    = '0;
    rk_last   = 1'b0;

    case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          state_d  = SEND;
          rk_buf_d = round_keys_c;
          idx_d    = FIRST_IDX;
        end
      end

      SEND: begin
        rk_valid = 1'b1;
        busy     = 1'b1;
        rk       = rk_buf_q[idx_q];
        rk_idx   = idx_q;
        rk_last  = (idx_q == LAST_IDX);
        // Flush wins over a simultaneous handshake: that beat is not consumed.
        if (flush) begin
          state_d  = IDLE;
          rk_buf_d = '0;
          idx_d    = '0;
        end else if (rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else if (REVERSE) begin
            idx_d = idx_q - IDX_W'(1);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_decrypt_key_feeder.sv
// Directed bench: one reverse-order and one forward-order feeder share inputs.
module tb_decrypt_key_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [31:0] key;
  logic        rk_ready;
  logic        flush;

  logic       key_ready_r, rk_valid_r, rk_last_r, busy_r;
  logic [7:0] rk_r;
  logic [1:0] rk_idx_r;
  logic       key_ready_f, rk_valid_f, rk_last_f, busy_f;
  logic [7:0] rk_f;
  logic [1:0] rk_idx_f;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decrypt_key_feeder #(.REVERSE(1'b1)) u_dut_rev (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready_r), .key(key),
    .rk_valid(rk_valid_r), .rk_ready(rk_ready), .rk(rk_r), .rk_idx(rk_idx_r),
    .rk_last(rk_last_r), .flush(flush), .busy(busy_r)
  );

  decrypt_key_feeder #(.REVERSE(1'b0)) u_dut_fwd (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready_f), .key(key),
    .rk_valid(rk_valid_f), .rk_ready(rk_ready), .rk(rk_f), .rk_idx(rk_idx_f),
    .rk_last(rk_last_f), .flush(flush), .busy(busy_f)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sampling and driving happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, " key_ready"}, 32'(key_ready_r), 32'd1);
    check_val({tag, " rk_valid"},  32'(rk_valid_r),  32'd0);
    check_val({tag, " busy"},      32'(busy_r),      32'd0);
    check_val({tag, " rk"},        32'(rk_r),        32'd0);
    check_val({tag, " rk_idx"},    32'(rk_idx_r),    32'd0);
    check_val({tag, " rk_last"},   32'(rk_last_r),   32'd0);
  endtask

  // Offer a key, waiting (bounded) for key_ready; returns in the first SEND cycle.
  task automatic offer_key(input string tag, input logic [31:0] k);
    int waited = 0;
    key       = k;
    key_valid = 1'b1;
    while (key_ready_r !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    if (key_ready_r !== 1'b1) check_val({tag, " accept timeout"}, 32'(key_ready_r), 32'd1);
    step();
    key_valid = 1'b0;
  endtask

  // Four beats with rk_ready held high; seq_* holds the first beat in bits [31:24].
  task automatic expect_beats(input string tag, input logic [31:0] seq_r, input logic [31:0] seq_f);
    rk_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      logic [7:0] er, ef;
      er = 8'(seq_r >> (8 * (3 - b)));
      ef = 8'(seq_f >> (8 * (3 - b)));
      check_val($sformatf("%s b%0d rk_valid", tag, b),  32'(rk_valid_r),  32'd1);
      check_val($sformatf("%s b%0d busy", tag, b),      32'(busy_r),      32'd1);
      check_val($sformatf("%s b%0d key_ready", tag, b), 32'(key_ready_r), 32'd0);
      check_val($sformatf("%s b%0d rk", tag, b),        32'(rk_r),        32'(er));
      check_val($sformatf("%s b%0d rk_idx", tag, b),    32'(rk_idx_r),    32'(3 - b));
      check_val($sformatf("%s b%0d rk_last", tag, b),   32'(rk_last_r),   32'(b == 3));
      check_val($sformatf("%s b%0d fwd rk", tag, b),    32'(rk_f),        32'(ef));
      check_val($sformatf("%s b%0d fwd rk_idx", tag, b), 32'(rk_idx_f),   32'(b));
      check_val($sformatf("%s b%0d fwd rk_last", tag, b), 32'(rk_last_f), 32'(b == 3));
      step();
    end
    check_val({tag, " end key_ready"}, 32'(key_ready_r), 32'd1);
    check_val({tag, " end rk_valid"},  32'(rk_valid_r),  32'd0);
    check_val({tag, " end rk"},        32'(rk_r),        32'd0);
    check_val({tag, " end fwd key_ready"}, 32'(key_ready_f), 32'd1);
  endtask

  task automatic check_beat(input string tag, input logic [7:0] er, input logic [1:0] ei, input logic el);
    check_val({tag, " rk_valid"}, 32'(rk_valid_r), 32'd1);
    check_val({tag, " rk"},       32'(rk_r),       32'(er));
    check_val({tag, " rk_idx"},   32'(rk_idx_r),   32'(ei));
    check_val({tag, " rk_last"},  32'(rk_last_r),  32'(el));
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key = '0; rk_ready = 1'b0; flush = 1'b0;
    step(); step();
    rst = 1'b0;
    check_idle("reset");
    check_val("reset fwd key_ready", 32'(key_ready_f), 32'd1);

    // Even parity: S = 5c7a336b.
    offer_key("even", 32'h57a336bc);
    expect_beats("even", 32'h5c7a336b, 32'h6b337a5c);

    // Odd parity: direct byte split.
    offer_key("odd", 32'h35ab674f);
    expect_beats("odd", 32'h35ab674f, 32'h4f67ab35);

    // Back-to-back: second key held valid throughout, accepted right after the last beat.
    offer_key("zero", 32'h00000000);
    key = 32'hffffffff; key_valid = 1'b1;
    expect_beats("zero", 32'h00000000, 32'h00000000);
    offer_key("ones", 32'hffffffff);
    expect_beats("ones", 32'hffffffff, 32'hffffffff);

    // Backpressure on the second beat.
    offer_key("bp", 32'h57a336bc);
    rk_ready = 1'b1;
    check_beat("bp b0", 8'h5c, 2'd3, 1'b0);
    step();
    rk_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_beat($sformatf("bp hold%0d", c), 8'h7a, 2'd2, 1'b0);
      step();
    end
    rk_ready = 1'b1;
    check_beat("bp b1", 8'h7a, 2'd2, 1'b0);
    step();
    check_beat("bp b2", 8'h33, 2'd1, 1'b0);
    step();
    check_beat("bp b3", 8'h6b, 2'd0, 1'b1);
    step();
    check_idle("bp end");

    // Flush together with a handshake on the 33 beat.
    offer_key("fl", 32'h57a336bc);
    rk_ready = 1'b1;
    check_beat("fl b0", 8'h5c, 2'd3, 1'b0);
    step();
    check_beat("fl b1", 8'h7a, 2'd2, 1'b0);
    step();
    flush = 1'b1;
    check_beat("fl b2", 8'h33, 2'd1, 1'b0);
    step();
    flush = 1'b0;
    check_idle("fl after");
    offer_key("fl new", 32'h35ab674f);
    expect_beats("fl new", 32'h35ab674f, 32'h4f67ab35);

    // Flush in IDLE does not block a key offered the same cycle.
    flush = 1'b1;
    offer_key("fl idle", 32'h35ab674f);
    flush = 1'b0;
    expect_beats("fl idle", 32'h35ab674f, 32'h4f67ab35);

    // Key offered while busy is ignored.
    offer_key("busy", 32'h57a336bc);
    rk_ready = 1'b1;
    check_beat("busy b0", 8'h5c, 2'd3, 1'b0);
    step();
    key = 32'h35ab674f; key_valid = 1'b1;
    check_beat("busy b1", 8'h7a, 2'd2, 1'b0);
    step();
    key_valid = 1'b0;
    check_beat("busy b2", 8'h33, 2'd1, 1'b0);
    step();
    check_beat("busy b3", 8'h6b, 2'd0, 1'b1);
    step();
    check_idle("busy end");
    step();
    check_idle("busy end+1");

    // Reset mid-stream at the second beat.
    offer_key("rst", 32'h57a336bc);
    rk_ready = 1'b1;
    check_beat("rst b0", 8'h5c, 2'd3, 1'b0);
    step();
    check_beat("rst b1", 8'h7a, 2'd2, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("rst after");
    check_val("rst fwd busy", 32'(busy_f), 32'd0);
    step();
    check_idle("rst after+1");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
